// File: rtl/p09_sprite_pkg.sv
// Shared types and constants for the multi-sprite renderer: register map,
// control-bit layout, per-sprite state record and reset-value helpers.
package p09_sprite_pkg;

    localparam int POS_BITS_C   = 8;
    localparam int COLOR_BITS_C = 6;
    localparam int CTRL_BITS    = 4;

    // Control register bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_MOVE  = 1;
    localparam int CTRL_DIR_X = 2;   // 0 = +1, 1 = -1
    localparam int CTRL_DIR_Y = 3;   // 0 = +1, 1 = -1

    localparam logic [COLOR_BITS_C-1:0] DEFAULT_COLOR = 6'b110001;

    typedef enum logic [1:0] {
        ADDR_X     = 2'd0,
        ADDR_Y     = 2'd1,
        ADDR_COLOR = 2'd2,
        ADDR_CTRL  = 2'd3
    } cfg_addr_e;

    typedef struct packed {
        logic [POS_BITS_C-1:0]   x;
        logic [POS_BITS_C-1:0]   y;
        logic [COLOR_BITS_C-1:0] color;
        logic [CTRL_BITS-1:0]    ctrl;
    } sprite_state_t;

    // Rotate a colour left by n positions (n taken modulo the colour width)
    function automatic logic [COLOR_BITS_C-1:0] rotl_color(input logic [COLOR_BITS_C-1:0] c,
                                                           input int n);
        logic [COLOR_BITS_C-1:0] r;
        r = c;
        for (int k = 0; k < COLOR_BITS_C; k++) begin
            if (k < (n % COLOR_BITS_C)) begin
                r = {r[COLOR_BITS_C-2:0], r[COLOR_BITS_C-1]};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Power-up state of sprite idx: staggered diagonally, moving down-right
    function automatic sprite_state_t reset_state(input int idx);
        sprite_state_t s;
        s.x     = POS_BITS_C'(16 * idx);
        s.y     = POS_BITS_C'(8 * idx);
        s.color = rotl_color(DEFAULT_COLOR, idx);
        s.ctrl  = 4'b0011;
        return s;
    endfunction

endpackage

// File: rtl/p09_sprite_channel.sv
// One sprite channel: config registers, bitmap store, per-line row fetch,
// visibility test, pixel bit and bounce movement.
module p09_sprite_channel
    import p09_sprite_pkg::*;
#(
    parameter int IDX           = 0,
    parameter int SPRITE_WIDTH  = 12,
    parameter int SPRITE_HEIGHT = 12,
    parameter int WIDTH_SMALL   = 100,
    parameter int HEIGHT_SMALL  = 75,
    parameter int POS_BITS      = POS_BITS_C,
    parameter int COLOR_BITS    = COLOR_BITS_C,
    parameter int ROW_BITS      = $clog2(SPRITE_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    next_frame,
    input  logic                    new_line,
    input  logic signed [POS_BITS:0] pos_h,
    input  logic signed [POS_BITS:0] pos_v,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [7:0]              cfg_wdata,
    input  logic                    bm_we,
    input  logic [ROW_BITS-1:0]     bm_row,
    input  logic [SPRITE_WIDTH-1:0] bm_data,
    output logic                    pix_bit,
    output logic [COLOR_BITS-1:0]   color
);

    // One extra bit beyond the signed position so x+width never wraps
    localparam int CW = POS_BITS + 2;
    localparam logic [POS_BITS-1:0] X_LIM = POS_BITS'(WIDTH_SMALL - SPRITE_WIDTH);
    localparam logic [POS_BITS-1:0] Y_LIM = POS_BITS'(HEIGHT_SMALL - SPRITE_HEIGHT);
    localparam sprite_state_t RST_STATE = reset_state(IDX);

    sprite_state_t             state_r;
    logic [SPRITE_WIDTH-1:0]   bitmap_r [SPRITE_HEIGHT];
    logic [SPRITE_WIDTH-1:0]   row_r;
    logic [SPRITE_WIDTH-1:0]   fetch_s;
    logic [SPRITE_WIDTH-1:0]   shifted_s;
    logic signed [CW-1:0]      h_s, v_s, x_lo_s, x_hi_s, y_lo_s, y_hi_s;
    logic [CW-1:0]             col_off_s, row_off_s;
    logic                      vis_h_s, vis_v_s, mv_en_s;
    logic [POS_BITS:0]         step_x_s, step_y_s;

    // One axis of bounce movement; returns {new_dir, new_pos}. Positions past
    // the upper bound flip and hold so an out-of-range sprite walks back in.
    function automatic logic [POS_BITS:0] step_axis(input logic [POS_BITS-1:0] p,
                                                    input logic dir_neg,
                                                    input logic [POS_BITS-1:0] lim);
        logic [POS_BITS:0] r;
        if (!dir_neg) begin
            if (p >= lim) begin
                r = {1'b1, p};
            end else begin
                r = {1'b0, p + POS_BITS'(1)};
            end
        end else begin
            if (p == POS_BITS'(0)) begin
                r = {1'b0, p};
            end else begin
                r = {1'b1, p - POS_BITS'(1)};
            end
        end
        return r;
    endfunction

    assign h_s       = {pos_h[POS_BITS], pos_h};
    assign v_s       = {pos_v[POS_BITS], pos_v};
    assign x_lo_s    = {2'b00, state_r.x};
    assign y_lo_s    = {2'b00, state_r.y};
    assign x_hi_s    = x_lo_s + CW'(SPRITE_WIDTH);
    assign y_hi_s    = y_lo_s + CW'(SPRITE_HEIGHT);
    assign vis_h_s   = (h_s >= x_lo_s) && (h_s < x_hi_s);
    assign vis_v_s   = (v_s >= y_lo_s) && (v_s < y_hi_s);
    assign col_off_s = h_s - x_lo_s;
    assign row_off_s = v_s - y_lo_s;
    assign shifted_s = row_r << col_off_s;
    assign pix_bit   = state_r.ctrl[CTRL_EN] & vis_h_s & vis_v_s & shifted_s[SPRITE_WIDTH-1];
    assign color     = state_r.color;
    assign mv_en_s   = next_frame & state_r.ctrl[CTRL_MOVE];
    assign step_x_s  = step_axis(state_r.x, state_r.ctrl[CTRL_DIR_X], X_LIM);
    assign step_y_s  = step_axis(state_r.y, state_r.ctrl[CTRL_DIR_Y], Y_LIM);

    // Select the bitmap row addressed by the current line offset
    always_comb begin
        fetch_s = '0;
        for (int r = 0; r < SPRITE_HEIGHT; r++) begin
            fetch_s = (row_off_s == CW'(r)) ? bitmap_r[r] : fetch_s;
        end
    end

    // Sprite registers: movement on frame end, config writes take precedence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RST_STATE;
        end else begin
            if (mv_en_s) begin
                state_r.x                <= step_x_s[POS_BITS-1:0];
                state_r.ctrl[CTRL_DIR_X] <= step_x_s[POS_BITS];
                state_r.y                <= step_y_s[POS_BITS-1:0];
                state_r.ctrl[CTRL_DIR_Y] <= step_y_s[POS_BITS];
            end
            if (cfg_we) begin
                case (cfg_addr_e'(cfg_addr))
                    ADDR_X:     state_r.x     <= POS_BITS'(cfg_wdata);
                    ADDR_Y:     state_r.y     <= POS_BITS'(cfg_wdata);
                    ADDR_COLOR: state_r.color <= cfg_wdata[COLOR_BITS-1:0];
                    ADDR_CTRL:  state_r.ctrl  <= cfg_wdata[CTRL_BITS-1:0];
                    default:    state_r       <= state_r;
                endcase
            end
        end
    end

    // Bitmap store and line buffer; a same-cycle write lands after the fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_r <= '0;
            for (int r = 0; r < SPRITE_HEIGHT; r++) begin
                bitmap_r[r] <= '0;
            end
        end else begin
            if (new_line) begin
                row_r <= vis_v_s ? fetch_s : '0;
            end
            if (bm_we && (bm_row < ROW_BITS'(SPRITE_HEIGHT))) begin
                bitmap_r[bm_row] <= bm_data;
            end
        end
    end

endmodule

// File: rtl/p09_sprite_engine.sv
// Multi-sprite renderer: per-pixel priority between sprite channels,
// registered render outputs and once-per-frame collision reporting.
module p09_sprite_engine
    import p09_sprite_pkg::*;
#(
    parameter int NUM_SPRITES   = 4,
    parameter int SPRITE_WIDTH  = 12,
    parameter int SPRITE_HEIGHT = 12,
    parameter int WIDTH_SMALL   = 100,
    parameter int HEIGHT_SMALL  = 75,
    parameter int POS_BITS      = POS_BITS_C,
    parameter int COLOR_BITS    = COLOR_BITS_C
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             next_frame,
    input  logic                             new_line,
    input  logic                             blank,
    input  logic signed [POS_BITS:0]         pos_h,
    input  logic signed [POS_BITS:0]         pos_v,
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_SPRITES)-1:0]   cfg_sel,
    input  logic [1:0]                       cfg_addr,
    input  logic [7:0]                       cfg_wdata,
    input  logic                             bm_we,
    input  logic [$clog2(NUM_SPRITES)-1:0]   bm_sel,
    input  logic [$clog2(SPRITE_HEIGHT)-1:0] bm_row,
    input  logic [SPRITE_WIDTH-1:0]          bm_data,
    output logic                             sprite_hit,
    output logic [COLOR_BITS-1:0]            sprite_color,
    output logic [$clog2(NUM_SPRITES)-1:0]   hit_index,
    output logic [NUM_SPRITES-1:0]           collision_mask,
    output logic                             collision_irq
);

    localparam int SB = $clog2(NUM_SPRITES);

    logic [NUM_SPRITES-1:0] pix_bits_s;
    logic [COLOR_BITS-1:0]  color_s [NUM_SPRITES];
    logic                   win_found_s;
    logic [COLOR_BITS-1:0]  win_color_s;
    logic [SB-1:0]          win_idx_s;
    logic                   multi_s;
    logic [NUM_SPRITES-1:0] coll_bits_s;
    logic [NUM_SPRITES-1:0] acc_next_s;

    logic                   hit_r;
    logic [COLOR_BITS-1:0]  color_r;
    logic [SB-1:0]          idx_r;
    logic [NUM_SPRITES-1:0] acc_r;
    logic [NUM_SPRITES-1:0] mask_r;
    logic                   irq_r;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
        p09_sprite_channel #(
            .IDX           (i),
            .SPRITE_WIDTH  (SPRITE_WIDTH),
            .SPRITE_HEIGHT (SPRITE_HEIGHT),
            .WIDTH_SMALL   (WIDTH_SMALL),
            .HEIGHT_SMALL  (HEIGHT_SMALL),
            .POS_BITS      (POS_BITS),
            .COLOR_BITS    (COLOR_BITS)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .next_frame (next_frame),
            .new_line   (new_line),
            .pos_h      (pos_h),
            .pos_v      (pos_v),
            .cfg_we     (cfg_we && (cfg_sel == SB'(i))),
            .cfg_addr   (cfg_addr),
            .cfg_wdata  (cfg_wdata),
            .bm_we      (bm_we && (bm_sel == SB'(i))),
            .bm_row     (bm_row),
            .bm_data    (bm_data),
            .pix_bit    (pix_bits_s[i]),
            .color      (color_s[i])
        );
    end

    // Lowest-indexed sprite with a set pixel wins; scan high to low
    always_comb begin
        win_found_s = 1'b0;
        win_color_s = '0;
        win_idx_s   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (pix_bits_s[i]) begin
                win_found_s = 1'b1;
                win_color_s = color_s[i];
                win_idx_s   = SB'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Two or more set bits: clearing the lowest set bit leaves something
    assign multi_s     = |(pix_bits_s & (pix_bits_s - NUM_SPRITES'(1)));
    assign coll_bits_s = (!blank && multi_s) ? pix_bits_s : '0;
    assign acc_next_s  = acc_r | coll_bits_s;

    // Render output registers, blanked to zero during hblank/vblank
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_r   <= 1'b0;
            color_r <= '0;
            idx_r   <= '0;
        end else if (blank) begin
            hit_r   <= 1'b0;
            color_r <= '0;
            idx_r   <= '0;
        end else begin
            hit_r   <= win_found_s;
            color_r <= win_color_s;
            idx_r   <= win_idx_s;
        end
    end

    // Collision accumulator, latched into the mask at frame end with an irq pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r  <= '0;
            mask_r <= '0;
            irq_r  <= 1'b0;
        end else if (next_frame) begin
            mask_r <= acc_next_s;
            acc_r  <= '0;
            irq_r  <= |acc_next_s;
        end else begin
            acc_r  <= acc_next_s;
            irq_r  <= 1'b0;
        end
    end

    assign sprite_hit     = hit_r;
    assign sprite_color   = color_r;
    assign hit_index      = idx_r;
    assign collision_mask = mask_r;
    assign collision_irq  = irq_r;

endmodule

// File: tb/tb_p09_sprite_engine.sv
// Self-checking bench for p09_sprite_engine: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model of the sprites.
module tb_p09_sprite_engine;

    localparam int NS   = 4;
    localparam int SW   = 12;
    localparam int SH   = 12;
    localparam int XMAX = 100 - SW;
    localparam int YMAX = 75 - SH;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              next_frame, new_line, blank;
    logic signed [8:0] pos_h, pos_v;
    logic              cfg_we;
    logic [1:0]        cfg_sel, cfg_addr;
    logic [7:0]        cfg_wdata;
    logic              bm_we;
    logic [1:0]        bm_sel;
    logic [3:0]        bm_row;
    logic [11:0]       bm_data;
    logic              sprite_hit;
    logic [5:0]        sprite_color;
    logic [1:0]        hit_index;
    logic [3:0]        collision_mask;
    logic              collision_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          mx [NS];
    int          my [NS];
    int          mcol [NS];
    int          mctrl [NS];
    logic [11:0] mbm [NS][SH];
    logic [11:0] mrow [NS];
    int          macc, mmask, mirq;

    p09_sprite_engine dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .next_frame     (next_frame),
        .new_line       (new_line),
        .blank          (blank),
        .pos_h          (pos_h),
        .pos_v          (pos_v),
        .cfg_we         (cfg_we),
        .cfg_sel        (cfg_sel),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .bm_we          (bm_we),
        .bm_sel         (bm_sel),
        .bm_row         (bm_row),
        .bm_data        (bm_data),
        .sprite_hit     (sprite_hit),
        .sprite_color   (sprite_color),
        .hit_index      (hit_index),
        .collision_mask (collision_mask),
        .collision_irq  (collision_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            int c;
            c = 6'b110001;
            for (int k = 0; k < i; k++) c = ((c << 1) | (c >> 5)) & 63;
            mx[i]    = 16 * i;
            my[i]    = 8 * i;
            mcol[i]  = c;
            mctrl[i] = 3;
            mrow[i]  = 12'h000;
            for (int r = 0; r < SH; r++) mbm[i][r] = 12'h000;
        end
        macc = 0; mmask = 0; mirq = 0;
    endtask

    // Apply the currently driven inputs for one clock and check all outputs
    task automatic cycle();
        int bits, cur, ph, pv, e_hit, e_col, e_idx;
        ph = int'(pos_h);
        pv = int'(pos_v);
        bits = 0;
        for (int i = 0; i < NS; i++) begin
            if (mctrl[i][0] && ph >= mx[i] && ph < mx[i] + SW && pv >= my[i] && pv < my[i] + SH)
                if (mrow[i][SW - 1 - (ph - mx[i])]) bits |= (1 << i);
        end
        e_hit = 0; e_col = 0; e_idx = 0;
        if (!blank) begin
            for (int i = NS - 1; i >= 0; i--)
                if (bits[i]) begin e_hit = 1; e_col = mcol[i]; e_idx = i; end
        end
        cur = (!blank && $countones(bits) >= 2) ? bits : 0;
        if (next_frame) begin
            mmask = macc | cur; mirq = (mmask != 0) ? 1 : 0; macc = 0;
        end else begin
            macc |= cur; mirq = 0;
        end
        if (new_line) begin
            for (int i = 0; i < NS; i++)
                mrow[i] = (pv >= my[i] && pv < my[i] + SH) ? mbm[i][pv - my[i]] : 12'h000;
        end
        if (bm_we && bm_row < SH) mbm[bm_sel][bm_row] = bm_data;
        if (next_frame) begin
            for (int i = 0; i < NS; i++) begin
                if (mctrl[i][1]) begin
                    if (!mctrl[i][2]) begin
                        if (mx[i] >= XMAX) mctrl[i] ^= 4; else mx[i]++;
                    end else begin
                        if (mx[i] == 0) mctrl[i] ^= 4; else mx[i]--;
                    end
                    if (!mctrl[i][3]) begin
                        if (my[i] >= YMAX) mctrl[i] ^= 8; else my[i]++;
                    end else begin
                        if (my[i] == 0) mctrl[i] ^= 8; else my[i]--;
                    end
                end
            end
        end
        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    mx[cfg_sel]    = int'(cfg_wdata);
                2'd1:    my[cfg_sel]    = int'(cfg_wdata);
                2'd2:    mcol[cfg_sel]  = int'(cfg_wdata) & 63;
                default: mctrl[cfg_sel] = int'(cfg_wdata) & 15;
            endcase
        end
        @(posedge clk);
        #1;
        chk("hit", sprite_hit, e_hit);
        chk("color", sprite_color, e_col);
        chk("index", hit_index, e_idx);
        chk("mask", collision_mask, mmask);
        chk("irq", collision_irq, mirq);
    endtask

    task automatic idle();
        next_frame = 1'b0; new_line = 1'b0; blank = 1'b0;
        pos_h = -9'sd1; pos_v = -9'sd1;
        cfg_we = 1'b0; bm_we = 1'b0;
    endtask

    task automatic wr_cfg(input int s, input int a, input int d);
        idle(); cfg_we = 1'b1; cfg_sel = 2'(s); cfg_addr = 2'(a); cfg_wdata = 8'(d);
        cycle(); idle();
    endtask

    task automatic wr_bm(input int s, input int r, input int d);
        idle(); bm_we = 1'b1; bm_sel = 2'(s); bm_row = 4'(r); bm_data = 12'(d);
        cycle(); idle();
    endtask

    task automatic fill_bm(input int s, input int d);
        for (int r = 0; r < SH; r++) wr_bm(s, r, d);
    endtask

    task automatic frame();
        idle(); next_frame = 1'b1; cycle(); idle();
    endtask

    task automatic line(input int v);
        idle(); new_line = 1'b1; pos_v = 9'(v); cycle(); idle();
    endtask

    task automatic pix(input int h, input int v);
        idle(); pos_h = 9'(h); pos_v = 9'(v); cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        cfg_sel = 2'd0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
        bm_sel = 2'd0; bm_row = 4'd0; bm_data = 12'd0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", sprite_hit, 0);
        chk("rst_color", sprite_color, 0);
        chk("rst_index", hit_index, 0);
        chk("rst_mask", collision_mask, 0);
        chk("rst_irq", collision_irq, 0);
        reset_n = 1'b1;

        // Reset positions advance by one after a frame
        for (int s = 0; s < NS; s++) fill_bm(s, 12'hFFF);
        frame();
        line(25);
        pix(49, 25); chk("s3_x49", sprite_hit, 1); chk("s3_idx", hit_index, 3);
        chk("s3_color", sprite_color, 6'b001110);
        pix(48, 25); chk("s3_x48", sprite_hit, 0);
        line(1);
        pix(1, 1);   chk("s0_x1", sprite_hit, 1); chk("s0_idx", hit_index, 0);
        pix(0, 1);   chk("s0_x0", sprite_hit, 0);
        line(0);
        pix(1, 0);   chk("s0_y0", sprite_hit, 0);

        // Single static sprite, leftmost bitmap pixel only
        wr_cfg(1, 3, 0); wr_cfg(2, 3, 0); wr_cfg(3, 3, 0);
        wr_cfg(0, 0, 10); wr_cfg(0, 1, 5); wr_cfg(0, 3, 1);
        wr_bm(0, 0, 12'h800);
        line(5);
        pix(10, 5); chk("px_hit", sprite_hit, 1); chk("px_color", sprite_color, 6'b110001);
        pix(11, 5); chk("px_next", sprite_hit, 0);

        // Overlapping sprites: priority and collision report
        wr_cfg(1, 0, 20); wr_cfg(1, 1, 20); wr_cfg(1, 3, 1);
        wr_cfg(0, 0, 20); wr_cfg(0, 1, 20);
        fill_bm(0, 12'hFFF);
        frame();
        line(20);
        pix(20, 20); chk("ov_hit", sprite_hit, 1); chk("ov_idx", hit_index, 0);
        frame();     chk("ov_mask", collision_mask, 4'b0011); chk("ov_irq", collision_irq, 1);
        idle(); cycle(); chk("ov_irq_once", collision_irq, 0);

        // Bounce at the right/bottom bounds
        wr_cfg(0, 3, 0); wr_cfg(1, 3, 0);
        wr_cfg(2, 0, 88); wr_cfg(2, 1, 63); wr_cfg(2, 3, 3);
        frame();
        line(63);
        pix(88, 63); chk("bx_hold", sprite_hit, 1); chk("bx_idx", hit_index, 2);
        pix(87, 63); chk("bx_hold_l", sprite_hit, 0);
        frame();
        line(62);
        pix(87, 62); chk("bx_back", sprite_hit, 1);
        pix(86, 62); chk("bx_back_l", sprite_hit, 0);
        line(74);
        pix(87, 74); chk("by_back", sprite_hit, 0);

        // Config write coinciding with frame end wins over movement
        wr_cfg(2, 3, 0);
        wr_cfg(3, 0, 10); wr_cfg(3, 1, 30); wr_cfg(3, 3, 3);
        idle(); next_frame = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd3; cfg_addr = 2'd0; cfg_wdata = 8'd40;
        cycle(); idle();
        line(31);
        pix(40, 31); chk("wr_x40", sprite_hit, 1); chk("wr_idx", hit_index, 3);
        pix(39, 31); chk("wr_x39", sprite_hit, 0);

        // Blanking hides overlap and suppresses collision accumulation
        wr_cfg(3, 3, 0); wr_cfg(0, 3, 1); wr_cfg(1, 3, 1);
        frame();
        line(20);
        for (int k = 0; k < 3; k++) begin
            idle(); blank = 1'b1; pos_h = 9'(20 + k); pos_v = 9'sd20; cycle();
            chk("bl_hit", sprite_hit, 0); chk("bl_color", sprite_color, 0); chk("bl_idx", hit_index, 0);
        end
        idle(); blank = 1'b1; next_frame = 1'b1; cycle(); idle();
        chk("bl_mask", collision_mask, 0); chk("bl_irq", collision_irq, 0);

        // Asynchronous reset mid-frame with a pending collision
        pix(20, 20); pix(21, 20);
        idle();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mr_hit", sprite_hit, 0); chk("mr_mask", collision_mask, 0); chk("mr_irq", collision_irq, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        frame();
        chk("mr_irq_frame", collision_irq, 0); chk("mr_mask_frame", collision_mask, 0);

        // Random stimulus against the model
        for (int s = 0; s < NS; s++)
            for (int r = 0; r < SH; r++) wr_bm(s, r, $urandom_range(0, 4095));
        for (int n = 0; n < 2500; n++) begin
            idle();
            pos_h      = 9'($urandom_range(0, 60) - 4);
            pos_v      = 9'($urandom_range(0, 50) - 4);
            new_line   = ($urandom_range(0, 7) == 0);
            next_frame = ($urandom_range(0, 63) == 0);
            blank      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                cfg_we   = 1'b1;
                cfg_sel  = 2'($urandom_range(0, 3));
                cfg_addr = 2'($urandom_range(0, 3));
                case (cfg_addr)
                    2'd0, 2'd1: cfg_wdata = 8'($urandom_range(0, 45));
                    2'd3:       cfg_wdata = 8'($urandom_range(0, 255) | 1);
                    default:    cfg_wdata = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                bm_we   = 1'b1;
                bm_sel  = 2'($urandom_range(0, 3));
                bm_row  = 4'($urandom_range(0, 15));
                bm_data = 12'($urandom_range(0, 4095));
            end
            cycle();
        end
        idle();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/p09_sprite_engine.md
Name: p09_sprite_engine

Overview:
- Multi-sprite renderer replacing the single-sprite path in the SVGA pipeline.
- Renders NUM_SPRITES independent sprites on the downscaled (8x8) pixel grid. Each sprite has its own position, colour, bitmap, bounce movement and enable.
- Resolves per-pixel priority and reports sprite-to-sprite collisions once per frame.
- Sits between the timing generators and final colour composition; configured through a register write port driven by the SPI receiver.

Parameters:
- NUM_SPRITES, 4, number of sprite channels (1..8)
- SPRITE_WIDTH, 12, sprite width in small pixels
- SPRITE_HEIGHT, 12, sprite height in small pixels
- WIDTH_SMALL, 100, visible width in small pixels
- HEIGHT_SMALL, 75, visible height in small pixels
- POS_BITS, 8, width of sprite x/y registers
- COLOR_BITS, 6, colour width (rrggbb)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- next_frame  in  1  one-cycle pulse at end of frame
- new_line  in  1  one-cycle pulse at start of each big (8-line) row
- blank  in  1  hblank|vblank
- pos_h  in  POS_BITS+1 (signed)  current small-pixel column
- pos_v  in  POS_BITS+1 (signed)  current small-pixel row
- cfg_we  in  1  register write strobe
- cfg_sel  in  $clog2(NUM_SPRITES)  target sprite
- cfg_addr  in  2  0=x, 1=y, 2=colour, 3=ctrl
- cfg_wdata  in  8  write data
- bm_we  in  1  bitmap row write strobe
- bm_sel  in  $clog2(NUM_SPRITES)  target sprite
- bm_row  in  $clog2(SPRITE_HEIGHT)  row index
- bm_data  in  SPRITE_WIDTH  row bits, MSB = leftmost pixel
- sprite_hit  out  1  a sprite pixel is set at the current position
- sprite_color  out  COLOR_BITS  colour of the winning sprite
- hit_index  out  $clog2(NUM_SPRITES)  winning sprite index
- collision_mask  out  NUM_SPRITES  sprites involved in a collision during the last frame
- collision_irq  out  1  one-cycle pulse after next_frame if collision_mask is non-zero

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, reset_n.
- Reset values:
  - x[i]=16*i, y[i]=8*i.
  - colour[i]=6'b110001 rotated left by i.
  - ctrl[i]: enable=1, move=1, dir_x=+1, dir_y=+1.
  - Bitmaps all zero.
  - All outputs 0.
- ctrl register bits: bit0 enable, bit1 move, bit2 dir_x (0=+1, 1=-1), bit3 dir_y.
  - Writes to cfg_addr=2 take cfg_wdata[COLOR_BITS-1:0].
  - A bm_sel or cfg_sel value >= NUM_SPRITES is ignored.
- Visibility of sprite i: pos_h >= x and pos_h < x+SPRITE_WIDTH, likewise for v. Comparisons are done at POS_BITS+2 width, so a negative pos never matches.
- Row fetch: on new_line, each sprite with v-visible loads row_reg[i] <= bitmap[i][pos_v - y]. Otherwise row_reg[i] is cleared.
- Pixel: bit_i = enable & visible_h & visible_v & row_reg[i][SPRITE_WIDTH-1-(pos_h-x)].
- Priority: the lowest index with bit_i=1 wins.
- Output timing: all render outputs are registered, with 1 clk latency from pos_h/pos_v. They are forced to 0 when blank=1.
- Collision: in any non-blank cycle with two or more bit_i set, those bits are OR'd into collision_acc.
  - On next_frame: collision_mask <= collision_acc | current-cycle bits; acc cleared; collision_irq=1 for one cycle if the loaded mask is non-zero.
- Movement: on next_frame, each sprite with move=1 steps x and y by ±1.
  - Bounce: at x=0 with dir -1, or x=WIDTH_SMALL-SPRITE_WIDTH with dir +1, the direction flips and the position stays for that frame. Same rule for y with HEIGHT_SMALL-SPRITE_HEIGHT.
  - Writes placing a sprite out of range are accepted; a sprite out of range moves back toward range in its dir and flips at the bound.
- Simultaneous events:
  - A cfg write in the same cycle as next_frame to the same sprite's x/y/ctrl wins over movement.
  - A bm_we to a row being fetched on new_line returns the old row; the new data appears on the next fetch.
- Reset mid-frame: all state returns to reset values immediately; no pulse is emitted.

Decomposition:
- Package p09_sprite_pkg: cfg_addr enum (ADDR_X, ADDR_Y, ADDR_COLOR, ADDR_CTRL), ctrl bit positions, default colour constant, sprite_state_t struct {x, y, color, ctrl}.
- Sub-module p09_sprite_channel, one per sprite, instantiated in a generate loop. It holds the registers, bitmap, row fetch, visibility and movement, and outputs bit_i and colour.
- The top level holds priority, collision logic and output registers.

Test Plan:
- Reset → x={0,16,32,48}, sprite_hit=0, collision_mask=0; one frame later x={1,17,33,49} and y={1,9,17,25}.
- Sprite 0 at x=10 y=5, move=0, bitmap row 0 = 12'h800; pos=(10,5) → sprite_hit=1 and sprite_color=6'b110001 one cycle later; pos=(11,5) → 0.
- Sprites 0 and 1 both at (20,20), all-ones bitmaps, move=0 → hit_index=0; after next_frame collision_mask=4'b0011 and collision_irq pulses once.
- Sprite at x=88 with dir +1 → next_frame keeps x=88 and flips dir; following frame x=87; same check at y=63.
- cfg write x=40 coinciding with next_frame → x=40, not 41.
- blank=1 with an overlapping visible sprite → all render outputs 0, no collision accumulated.
